dut_vector_harness: RTL and testbench

Stimulus/capture front end for the team's combinational 12-bit-in / 17-bit-out datapath blocks. It accepts test vectors on a valid/ready stream and drives them onto the datapath input bus. After a programmable settle time it samples the datapath output bus and returns the result on a second valid/ready stream. It also folds every captured result into a running MISR signature and a capture counter, so long regression runs can be checked with a single compare.

---
 rtl/dut_vector_harness_if.sv | 23 ++
 rtl/dut_vector_harness.sv | 110 +++++++++++
 tb/tb_dut_vector_harness.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dut_vector_harness_if.sv
// Vector-in / result-out valid-ready streams of the datapath harness.
// master = stimulus source and result sink, slave = harness.
interface dut_vector_harness_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 17
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dut_vector_harness.sv
// Drives vectors onto a combinational datapath, captures its response
// after a settle delay, and folds every capture into a MISR and counter.
module dut_vector_harness #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 17,
  parameter int SETTLE = 1,
  parameter logic [OUT_W-1:0] POLY = OUT_W'(17'h00009),
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  dut_vector_harness_if.slave vec,
  output logic [IN_W-1:0]    dut_in,
  input  logic [OUT_W-1:0]   dut_out,
  input  logic               sig_clear,
  output logic [OUT_W-1:0]   signature,
  output logic [CNT_W-1:0]   capture_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;

  logic             cap;
  logic [OUT_W-1:0] sig_base;
  logic [OUT_W-1:0] shifted;
  logic [CNT_W-1:0] ccnt_base;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dut_in_d = dut_in_q;
    out_d    = out_q;
    cap      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vec.in_valid) begin
          dut_in_d = vec.in_data;
          cnt_d    = SETTLE_M1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 8'd0) begin
          cap     = 1'b1;
          out_d   = dut_out;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (vec.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear in the capture cycle is applied first, so the capture lands
  // on a zeroed signature and counter.
  always_comb begin
    sig_base  = sig_clear ? '0 : sig_q;
    ccnt_base = sig_clear ? '0 : ccnt_q;
    shifted   = {sig_base[OUT_W-2:0], 1'b0};
    if (sig_base[OUT_W-1]) shifted = shifted ^ POLY;
    sig_d  = sig_base;
    ccnt_d = ccnt_base;
    if (cap) begin
      sig_d  = shifted ^ dut_out;
      ccnt_d = ccnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dut_in_q <= '0;
      out_q    <= '0;
      sig_q    <= '0;
      ccnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dut_in_q <= dut_in_d;
      out_q    <= out_d;
      sig_q    <= sig_d;
      ccnt_q   <= ccnt_d;
    end
  end

  assign vec.in_ready  = (state_q == IDLE);
  assign vec.out_valid = (state_q == HOLD);
  assign vec.out_data  = out_q;
  assign dut_in        = dut_in_q;
  assign signature     = sig_q;
  assign capture_count = ccnt_q;

endmodule

// File: tb/tb_dut_vector_harness.sv
// Bench for dut_vector_harness: two instances (SETTLE=1/CNT_W=4 and
// SETTLE=3/CNT_W=16) on shared stimulus, checked against a transaction model.
module tb_dut_vector_harness;

  localparam logic [16:0] POLY = 17'h00009;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [11:0] id = '0;
  logic        ordy = 1'b0;
  logic        clr = 1'b0;

  always #5 clk = ~clk;

  dut_vector_harness_if #(.IN_W(12), .OUT_W(17)) a_if ();
  dut_vector_harness_if #(.IN_W(12), .OUT_W(17)) b_if ();

  assign a_if.in_valid  = iv;
  assign a_if.in_data   = id;
  assign a_if.out_ready = ordy;
  assign b_if.in_valid  = iv;
  assign b_if.in_data   = id;
  assign b_if.out_ready = ordy;

  logic [11:0] a_din, b_din;
  logic [16:0] a_sig, b_sig;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;

  dut_vector_harness #(
    .IN_W(12), .OUT_W(17), .SETTLE(1), .POLY(POLY), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst), .vec(a_if.slave),
    .dut_in(a_din), .dut_out({5'b0, a_din}),
    .sig_clear(clr), .signature(a_sig), .capture_count(a_cnt)
  );

  dut_vector_harness #(
    .IN_W(12), .OUT_W(17), .SETTLE(3), .POLY(POLY), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .vec(b_if.slave),
    .dut_in(b_din), .dut_out({5'b0, b_din}),
    .sig_clear(clr), .signature(b_sig), .capture_count(b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Transaction model: a vector in flight, its age, a held result.
  int          settle_k[2] = '{1, 3};
  int          cmask[2]    = '{15, 65535};
  logic [11:0] m_drv[2];
  bit          m_pend[2];
  int          m_age[2];
  bit          m_hold[2];
  logic [16:0] m_res[2];
  logic [16:0] m_sig[2];
  int          m_cnt[2];

  function automatic logic [16:0] misr(input logic [16:0] s,
                                       input logic [16:0] v);
    logic [16:0] t;
    t = 17'((s * 2) % 18'h20000);
    if (s >= 17'h10000) t = t ^ POLY;
    return t ^ v;
  endfunction

  task mreset();
    for (int k = 0; k < 2; k++) begin
      m_drv[k] = '0; m_pend[k] = 0; m_age[k] = 0; m_hold[k] = 0;
      m_res[k] = '0; m_sig[k] = '0; m_cnt[k] = 0;
    end
  endtask

  task mstep(input int k);
    bit cap;
    cap = 0;
    if (m_hold[k]) begin
      if (ordy) m_hold[k] = 0;
    end else if (m_pend[k]) begin
      m_age[k]++;
      if (m_age[k] == settle_k[k]) begin
        cap = 1;
        m_res[k] = {5'b0, m_drv[k]};
        m_hold[k] = 1;
        m_pend[k] = 0;
      end
    end else if (iv) begin
      m_drv[k] = id; m_pend[k] = 1; m_age[k] = 0;
    end
    if (clr) begin
      m_sig[k] = '0; m_cnt[k] = 0;
    end
    if (cap) begin
      m_sig[k] = misr(m_sig[k], m_res[k]);
      m_cnt[k]++;
    end
  endtask

  always @(posedge rst) mreset();

  always @(negedge clk) begin
    if (rst) mreset();
    else begin
      mstep(0);
      mstep(1);
    end
    chk("A.in_ready", 32'(a_if.in_ready), 32'(!(m_pend[0] || m_hold[0])));
    chk("A.out_valid", 32'(a_if.out_valid), 32'(m_hold[0]));
    chk("A.out_data", 32'(a_if.out_data), 32'(m_res[0]));
    chk("A.dut_in", 32'(a_din), 32'(m_drv[0]));
    chk("A.signature", 32'(a_sig), 32'(m_sig[0]));
    chk("A.count", 32'(a_cnt), 32'(m_cnt[0] & cmask[0]));
    chk("B.in_ready", 32'(b_if.in_ready), 32'(!(m_pend[1] || m_hold[1])));
    chk("B.out_valid", 32'(b_if.out_valid), 32'(m_hold[1]));
    chk("B.out_data", 32'(b_if.out_data), 32'(m_res[1]));
    chk("B.dut_in", 32'(b_din), 32'(m_drv[1]));
    chk("B.signature", 32'(b_sig), 32'(m_sig[1]));
    chk("B.count", 32'(b_cnt), 32'(m_cnt[1] & cmask[1]));
  end

  task tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(a_if.in_ready && b_if.in_ready) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(a_if.in_ready && b_if.in_ready), 32'd1);
  endtask

  task automatic send(input logic [11:0] v);
    iv = 1'b1;
    id = v;
    tick();
    iv = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".A.out_valid"}, 32'(a_if.out_valid), 0);
    chk({tag, ".A.in_ready"}, 32'(a_if.in_ready), 1);
    chk({tag, ".A.out_data"}, 32'(a_if.out_data), 0);
    chk({tag, ".A.dut_in"}, 32'(a_din), 0);
    chk({tag, ".A.sig"}, 32'(a_sig), 0);
    chk({tag, ".A.cnt"}, 32'(a_cnt), 0);
    chk({tag, ".B.out_valid"}, 32'(b_if.out_valid), 0);
    chk({tag, ".B.dut_in"}, 32'(b_din), 0);
    chk({tag, ".B.sig"}, 32'(b_sig), 0);
    chk({tag, ".B.cnt"}, 32'(b_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int acc;
    int cyc;
    int msb_seen;

    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;

    tick();
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (a_if.out_valid || b_if.out_valid) bad++;
    end
    chk("idle_no_valid", 32'(bad), 0);

    ordy = 1'b1;
    send(12'hABC);
    chk("abc.dut_in", 32'(a_din), 32'h00ABC);
    chk("abc.pre_valid", 32'(a_if.out_valid), 0);
    tick();
    chk("abc.out_valid", 32'(a_if.out_valid), 1);
    chk("abc.out_data", 32'(a_if.out_data), 32'h00ABC);
    chk("abc.sig", 32'(a_sig), 32'h00ABC);
    chk("abc.cnt", 32'(a_cnt), 1);
    tick();
    chk("abc.post_valid", 32'(a_if.out_valid), 0);
    chk("abc.in_ready", 32'(a_if.in_ready), 1);

    wait_idle();
    send(12'h001);
    wait_idle();
    chk("v2.A.sig", 32'(a_sig), 32'h01579);
    chk("v2.A.cnt", 32'(a_cnt), 2);
    chk("v2.B.sig", 32'(b_sig), 32'h01579);
    chk("v2.B.cnt", 32'(b_cnt), 2);

    ordy = 1'b0;
    send(12'h3C5);
    repeat (3) tick();
    chk("bp.B.valid", 32'(b_if.out_valid), 1);
    chk("bp.B.data", 32'(b_if.out_data), 32'h003C5);
    bad = 0;
    repeat (10) begin
      iv = 1'($urandom_range(0, 1));
      id = 12'($urandom);
      tick();
      if (b_if.out_data !== 17'h003C5 || b_if.in_ready !== 1'b0 ||
          b_if.out_valid !== 1'b1 || a_din !== 12'h3C5) bad++;
    end
    chk("bp.stable", 32'(bad), 0);
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    chk("bp.B.valid_drop", 32'(b_if.out_valid), 0);
    chk("bp.B.in_ready", 32'(b_if.in_ready), 1);

    wait_idle();
    send(12'h005);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrcap.A.sig", 32'(a_sig), 32'h00005);
    chk("clrcap.A.cnt", 32'(a_cnt), 1);
    wait_idle();
    chk("clrcap.B.sig", 32'(b_sig), 32'h00005);
    chk("clrcap.B.cnt", 32'(b_cnt), 1);

    ordy = 1'b0;
    send(12'h123);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr.A.sig", 32'(a_sig), 0);
    chk("clr.A.cnt", 32'(a_cnt), 0);
    chk("clr.A.valid", 32'(a_if.out_valid), 1);
    chk("clr.A.data", 32'(a_if.out_data), 32'h00123);
    chk("clr.A.dut_in", 32'(a_din), 32'h123);
    ordy = 1'b1;
    wait_idle();

    clr = 1'b1;
    tick();
    clr = 1'b0;
    send(12'hFFF);
    wait_idle();
    repeat (6) begin
      send(12'h000);
      wait_idle();
    end
    chk("poly.A.sig", 32'(a_sig), 32'h1FFC9);
    chk("poly.A.cnt", 32'(a_cnt), 7);
    chk("poly.B.sig", 32'(b_sig), 32'h1FFC9);

    ordy = 1'b0;
    send(12'h7FF);
    tick();
    rst = 1'b1;
    #1;
    chk_zero("rst_op");
    #1;
    rst = 1'b0;
    ordy = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (a_if.out_valid || b_if.out_valid) bad++;
    end
    chk("rst_op.no_result", 32'(bad), 0);
    send(12'h0F0);
    wait_idle();
    chk("fresh.A.sig", 32'(a_sig), 32'h000F0);
    chk("fresh.A.cnt", 32'(a_cnt), 1);
    chk("fresh.B.data", 32'(b_if.out_data), 32'h000F0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (16) begin
      send(12'($urandom));
      wait_idle();
    end
    chk("wrap.A.cnt", 32'(a_cnt), 0);
    chk("wrap.B.cnt", 32'(b_cnt), 16);

    acc = 0;
    cyc = 0;
    msb_seen = 0;
    while (acc < 1000 && cyc < 30000) begin
      iv   = ($urandom_range(0, 3) != 0);
      id   = 12'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      clr  = ($urandom_range(0, 63) == 0);
      if (iv && a_if.in_ready) acc++;
      tick();
      cyc++;
      if (a_sig[16]) msb_seen++;
    end
    iv = 1'b0;
    clr = 1'b0;
    ordy = 1'b1;
    chk("rand.accepts", 32'(acc), 1000);
    chk("rand.msb_cover", 32'(msb_seen > 0), 1);
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
